// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard encoder: frame FSM states,
// prefix/response byte values, ps2_key field offsets and small byte helpers.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } frame_state_e;

    localparam logic [7:0] CODE_E0 = 8'hE0;
    localparam logic [7:0] CODE_F0 = 8'hF0;
    localparam logic [7:0] CODE_E1 = 8'hE1;
    localparam logic [7:0] CODE_AA = 8'hAA;
    localparam logic [7:0] CODE_FA = 8'hFA;
    localparam logic [7:0] CODE_EE = 8'hEE;
    localparam logic [7:0] CODE_FE = 8'hFE;
    localparam logic [7:0] CODE_00 = 8'h00;
    localparam logic [7:0] CODE_FF = 8'hFF;

    localparam int KEY_TOGGLE_BIT  = 10;
    localparam int KEY_PRESSED_BIT = 9;
    localparam int KEY_EXT_BIT     = 8;
    localparam int KEY_CODE_MSB    = 7;
    localparam int KEY_CODE_LSB    = 0;

    // Odd parity holds when data bits plus parity bit contain an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

    function automatic logic is_response(input logic [7:0] b);
        logic r;
        case (b)
            CODE_AA, CODE_FA, CODE_EE, CODE_FE, CODE_00, CODE_FF: r = 1'b1;
            default:                                              r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronises both PS/2 lines, glitch-filters the clock line and flags each
// falling edge of the filtered clock as a one-cycle sample event.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clk_raw,
    input  logic data_raw,
    output logic clk_fall,
    output logic data_sync
);
    localparam logic [7:0] CNT_MAX = 8'(FILTER_LEN - 1);

    logic [1:0] clk_sync_q, clk_sync_d;
    logic [1:0] data_sync_q, data_sync_d;
    logic [7:0] cnt_q, cnt_d;
    logic       filt_q, filt_d;
    logic       filt_dly_q, filt_dly_d;
    logic       fall_q, fall_d;

    // Filter counter counts consecutive samples disagreeing with the filtered level.
    always_comb begin
        clk_sync_d  = {clk_sync_q[0], clk_raw};
        data_sync_d = {data_sync_q[0], data_raw};
        filt_d      = filt_q;
        cnt_d       = 8'd0;
        if (clk_sync_q[1] != filt_q) begin
            if (cnt_q == CNT_MAX) begin
                filt_d = clk_sync_q[1];
                cnt_d  = 8'd0;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end else begin
            cnt_d = 8'd0;
        end
        filt_dly_d = filt_q;
        fall_d     = filt_dly_q & ~filt_q;
    end

    // Line state registers; idle PS/2 lines are high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            cnt_q       <= 8'd0;
            filt_q      <= 1'b1;
            filt_dly_q  <= 1'b1;
            fall_q      <= 1'b0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            cnt_q       <= cnt_d;
            filt_q      <= filt_d;
            filt_dly_q  <= filt_dly_d;
            fall_q      <= fall_d;
        end
    end

    assign clk_fall  = fall_q;
    assign data_sync = data_sync_q[1];

endmodule

// File: rtl/ps2_key_encoder.sv
// Turns a raw PS/2 device-to-host stream into the 11-bit ps2_key event word:
// frame FSM with watchdog, then E0/F0/E1 prefix decoding.
module ps2_key_encoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 65535
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        key_strobe,
    output logic        frame_err
);
    localparam int              WD_W   = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

    logic [1:0]      rst_sync_q, rst_sync_d;
    logic            rst_n_s, sample_s, data_s, perr_s, timeout_s;
    frame_state_e    state_q, state_d;
    logic [2:0]      bitcnt_q, bitcnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_q, par_d;
    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            byte_vld_q, byte_vld_d;
    logic [7:0]      byte_q, byte_d;
    logic            err_q, err_d;
    logic            ext_q, ext_d, rel_q, rel_d;
    logic [2:0]      skip_q, skip_d;
    logic [10:0]     key_q, key_d;
    logic            strobe_q, strobe_d;

    assign rst_sync_d = {rst_sync_q[0], 1'b1};
    assign rst_n_s    = rst_sync_q[1];

    // Reset asserts immediately but releases on a clk_sys edge.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_line (
        .clk       (clk_sys),
        .rst_n     (rst_n_s),
        .clk_raw   (ps2_clk),
        .data_raw  (ps2_data),
        .clk_fall  (sample_s),
        .data_sync (data_s)
    );

    // Frame FSM and watchdog; a sample event always beats a simultaneous timeout.
    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        byte_vld_d = 1'b0;
        byte_d     = byte_q;
        perr_s     = 1'b0;
        timeout_s  = (state_q != ST_IDLE) && !sample_s && (wdog_q == WD_MAX);
        if ((state_q == ST_IDLE) || sample_s) begin
            wdog_d = '0;
        end else if (wdog_q != WD_MAX) begin
            wdog_d = wdog_q + 1'b1;
        end else begin
            wdog_d = wdog_q;
        end
        case (state_q)
            ST_IDLE: begin
                if (sample_s && !data_s) begin
                    state_d  = ST_DATA;
                    bitcnt_d = 3'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (sample_s) begin
                    shift_d  = {data_s, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else if (timeout_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (sample_s) begin
                    par_d   = data_s;
                    state_d = ST_STOP;
                end else if (timeout_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (sample_s) begin
                    state_d = ST_IDLE;
                    if (data_s && odd_parity_ok(shift_q, par_q)) begin
                        byte_vld_d = 1'b1;
                        byte_d     = shift_q;
                    end else begin
                        perr_s = 1'b1;
                    end
                end else if (timeout_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        err_d = perr_s | timeout_s;
    end

    // Byte decoder; a bad frame clears prefixes, a timeout leaves them alone.
    always_comb begin
        ext_d    = ext_q;
        rel_d    = rel_q;
        skip_d   = skip_q;
        key_d    = key_q;
        strobe_d = 1'b0;
        if (perr_s) begin
            ext_d  = 1'b0;
            rel_d  = 1'b0;
            skip_d = 3'd0;
        end else if (byte_vld_q) begin
            if (skip_q != 3'd0) begin
                skip_d = skip_q - 3'd1;
            end else begin
                case (byte_q)
                    CODE_E0: ext_d = 1'b1;
                    CODE_F0: rel_d = 1'b1;
                    CODE_E1: begin
                        skip_d = 3'd7;
                        ext_d  = 1'b0;
                        rel_d  = 1'b0;
                    end
                    default: begin
                        if (!ext_q && !rel_q && is_response(byte_q)) begin
                            strobe_d = 1'b0;
                        end else begin
                            key_d[KEY_TOGGLE_BIT]              = ~key_q[KEY_TOGGLE_BIT];
                            key_d[KEY_PRESSED_BIT]             = ~rel_q;
                            key_d[KEY_EXT_BIT]                 = ext_q;
                            key_d[KEY_CODE_MSB:KEY_CODE_LSB]   = byte_q;
                            strobe_d                           = 1'b1;
                            ext_d                              = 1'b0;
                            rel_d                              = 1'b0;
                        end
                    end
                endcase
            end
        end else begin
            skip_d = skip_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_sys or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_q    <= ST_IDLE;
            bitcnt_q   <= 3'd0;
            shift_q    <= 8'd0;
            par_q      <= 1'b0;
            wdog_q     <= '0;
            byte_vld_q <= 1'b0;
            byte_q     <= 8'd0;
            err_q      <= 1'b0;
            ext_q      <= 1'b0;
            rel_q      <= 1'b0;
            skip_q     <= 3'd0;
            key_q      <= 11'd0;
            strobe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            wdog_q     <= wdog_d;
            byte_vld_q <= byte_vld_d;
            byte_q     <= byte_d;
            err_q      <= err_d;
            ext_q      <= ext_d;
            rel_q      <= rel_d;
            skip_q     <= skip_d;
            key_q      <= key_d;
            strobe_q   <= strobe_d;
        end
    end

    assign ps2_key    = key_q;
    assign key_strobe = strobe_q;
    assign frame_err  = err_q;

endmodule
